aud_i2s_recorder: RTL and testbench

Receive-side counterpart of the audio DAC player. Deserialises the WM8731 ADC stream (I2S mode, 16-bit, codec is bus master) into 16-bit PCM words. Presents each word with a write pulse and an SRAM word address for the SRAM write path inside Top. Runs on the 12 MHz codec clock domain and is controlled by the debounced record/pause/stop key pulses.

---
 rtl/aud_i2s_recorder_if.sv | 28 ++
 rtl/aud_i2s_recorder.sv | 166 ++++++++++++++++
 tb/tb_aud_i2s_recorder.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aud_i2s_recorder_if.sv
// Port bundle for aud_i2s_recorder: key pulses, raw codec ADC pins and the SRAM write path.
// master = recorder side, slave = Top / SRAM writer side.
interface aud_i2s_recorder_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 20
);
  logic              i_start;
  logic              i_pause;
  logic              i_stop;
  logic              i_aud_bclk;
  logic              i_aud_lrck;
  logic              i_aud_adcdat;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic [ADDR_W-1:0] o_address;
  logic              o_busy;
  logic              o_full;

  modport master (
    input  i_start, i_pause, i_stop, i_aud_bclk, i_aud_lrck, i_aud_adcdat,
    output o_data, o_valid, o_address, o_busy, o_full
  );

  modport slave (
    output i_start, i_pause, i_stop, i_aud_bclk, i_aud_lrck, i_aud_adcdat,
    input  o_data, o_valid, o_address, o_busy, o_full
  );
endinterface

// File: rtl/aud_i2s_recorder.sv
// WM8731 I2S ADC deserialiser: 16-bit left-channel PCM words written to sequential SRAM addresses.
// Define AUD_I2S_REC_STEREO_EN to capture both channels and store their average instead.
module aud_i2s_recorder #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] MAX_ADDR = '1
) (
  input logic                i_clk,
  input logic                i_rst,
  aud_i2s_recorder_if.master bus
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    StIdle, StWaitLeft, StSkip, StShift, StStore, StPaused, StWaitRight
  } state_e;

  state_e            state_q;
  logic [2:0]        bclk_s;
  logic [2:0]        lrck_s;
  logic [1:0]        dat_s;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              valid_q;
  logic              full_q;

  logic              bclk_rise;
  logic              lrck_fall;
  logic [DATA_W-1:0] word;

  assign bclk_rise = bclk_s[1] & ~bclk_s[2];
  assign lrck_fall = ~lrck_s[1] & lrck_s[2];
  assign word      = {shift_q[DATA_W-2:0], dat_s[1]};

`ifdef AUD_I2S_REC_STEREO_EN
  logic              lrck_rise;
  logic              right_q;
  logic [DATA_W-1:0] left_q;
  logic [DATA_W:0]   sum;

  assign lrck_rise = lrck_s[1] & ~lrck_s[2];
  assign sum       = {left_q[DATA_W-1], left_q} + {word[DATA_W-1], word};
`endif

  // Outputs are loaded on entry to StStore so they are valid throughout the StStore cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      bclk_s  <= '0;
      lrck_s  <= '0;
      dat_s   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
`ifdef AUD_I2S_REC_STEREO_EN
      right_q <= 1'b0;
      left_q  <= '0;
`endif
    end else begin
      bclk_s  <= {bclk_s[1:0], bus.i_aud_bclk};
      lrck_s  <= {lrck_s[1:0], bus.i_aud_lrck};
      dat_s   <= {dat_s[0], bus.i_aud_adcdat};
      valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!bus.i_stop && bus.i_start) begin
            ptr_q   <= '0;
            full_q  <= 1'b0;
            state_q <= StWaitLeft;
          end
        end
        StPaused: begin
          if (bus.i_stop) state_q <= StIdle;
          else if (bus.i_start) state_q <= StWaitLeft;
        end
        StWaitLeft: begin
          if (bus.i_stop) state_q <= StIdle;
          else if (bus.i_pause) state_q <= StPaused;
          else if (lrck_fall) begin
            cnt_q   <= '0;
`ifdef AUD_I2S_REC_STEREO_EN
            right_q <= 1'b0;
`endif
            state_q <= StSkip;
          end
        end
        StSkip: begin
          if (bus.i_stop) state_q <= StIdle;
          else if (bus.i_pause) state_q <= StPaused;
          else if (bclk_rise) state_q <= StShift;
        end
        StShift: begin
          if (bus.i_stop) state_q <= StIdle;
          else if (bus.i_pause) state_q <= StPaused;
          else if (lrck_fall) begin
            // Short frame: drop the partial word and resync on this new left slot.
            cnt_q   <= '0;
`ifdef AUD_I2S_REC_STEREO_EN
            right_q <= 1'b0;
`endif
            state_q <= StSkip;
          end else if (bclk_rise) begin
            shift_q <= word;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == CntW'(DATA_W - 1)) begin
`ifdef AUD_I2S_REC_STEREO_EN
              if (!right_q) begin
                left_q  <= word;
                state_q <= StWaitRight;
              end else begin
                data_q  <= sum[DATA_W:1];
                addr_q  <= ptr_q;
                valid_q <= 1'b1;
                state_q <= StStore;
              end
`else
              data_q  <= word;
              addr_q  <= ptr_q;
              valid_q <= 1'b1;
              state_q <= StStore;
`endif
            end
          end
        end
`ifdef AUD_I2S_REC_STEREO_EN
        StWaitRight: begin
          if (bus.i_stop) state_q <= StIdle;
          else if (bus.i_pause) state_q <= StPaused;
          else if (lrck_rise) begin
            cnt_q   <= '0;
            right_q <= 1'b1;
            state_q <= StSkip;
          end
        end
`endif
        StStore: begin
          if (ptr_q == MAX_ADDR) begin
            full_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            ptr_q <= ptr_q + 1'b1;
            if (bus.i_stop) state_q <= StIdle;
            else if (bus.i_pause) state_q <= StPaused;
            else state_q <= StWaitLeft;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.o_data    = data_q;
  assign bus.o_address = addr_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_full    = full_q;
  assign bus.o_busy    = (state_q != StIdle) && (state_q != StPaused);

endmodule

// File: tb/tb_aud_i2s_recorder.sv
// Directed bench for aud_i2s_recorder: frame-level recording model plus literal pins.
`timescale 1ns/1ps
module tb_aud_i2s_recorder;
  localparam int unsigned       DATA_W   = 16;
  localparam int unsigned       ADDR_W   = 20;
  localparam logic [ADDR_W-1:0] MAX_ADDR = 20'd3;
  localparam int                BclkHalf = 6;
  localparam int                MIdle = 0, MRec = 1, MPaused = 2;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aud_i2s_recorder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  aud_i2s_recorder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_ADDR(MAX_ADDR)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int                vectors     = 0;
  int                miscompares = 0;
  int                valid_cnt   = 0;
  logic [DATA_W-1:0] last_data   = '0;
  logic [ADDR_W-1:0] last_addr   = '0;
  time               lsb_t       = 0;
  exp_t              exp_q[$];

  int                m_mode = MIdle;
  logic [ADDR_W-1:0] m_ptr  = '0;
  logic              m_full = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_word(input logic [DATA_W-1:0] l,
                                                   input logic [DATA_W-1:0] r);
`ifdef AUD_I2S_REC_STEREO_EN
    int s;
    s = (int'($signed(l)) + int'($signed(r))) >>> 1;
    return s[DATA_W-1:0];
`else
    logic [DATA_W-1:0] unused_r;
    unused_r = r;
    return l;
`endif
  endfunction

  function automatic void model_pulse(input logic st, input logic pa, input logic sp);
    if (sp) m_mode = MIdle;
    else if (pa && m_mode == MRec) m_mode = MPaused;
    else if (st) begin
      if (m_mode == MIdle) begin
        m_ptr  = '0;
        m_full = 1'b0;
        m_mode = MRec;
      end else if (m_mode == MPaused) m_mode = MRec;
    end
  endfunction

  function automatic void model_store(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    exp_t e;
    e.data = model_word(l, r);
    e.addr = m_ptr;
    exp_q.push_back(e);
    if (m_ptr == MAX_ADDR) begin
      m_full = 1'b1;
      m_mode = MIdle;
    end else m_ptr = m_ptr + 1'b1;
  endfunction

  task automatic pulse(input logic st, input logic pa, input logic sp);
    @(negedge clk);
    bus.i_start = st; bus.i_pause = pa; bus.i_stop = sp;
    model_pulse(st, pa, sp);
    @(negedge clk);
    bus.i_start = 1'b0; bus.i_pause = 1'b0; bus.i_stop = 1'b0;
  endtask

  // One I2S frame: lrck toggles on a bclk fall, MSB follows one bclk later, sampled on rises.
  // Optional key pulses are injected on the rise of left-channel bit inj_bit.
  task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                            input int inj_bit, input logic st, input logic pa, input logic sp);
    logic [DATA_W-1:0] w;
    logic              was_rec;
    logic              aborted;
    int                store_half;
    was_rec = (m_mode == MRec);
    aborted = 1'b0;
`ifdef AUD_I2S_REC_STEREO_EN
    store_half = 1;
`else
    store_half = 0;
`endif
    for (int half = 0; half < 2; half++) begin
      w = (half == 0) ? l : r;
      for (int k = 0; k < 18; k++) begin
        @(negedge clk);
        bus.i_aud_bclk = 1'b0;
        if (k == 0) bus.i_aud_lrck = (half == 1);
        bus.i_aud_adcdat = (k >= 1 && k <= 16) ? w[16-k] : 1'b0;
        repeat (BclkHalf - 1) @(negedge clk);
        @(negedge clk);
        bus.i_aud_bclk = 1'b1;
        if (k == 16) begin
          lsb_t = $time;
          if (half == store_half && was_rec && !aborted && m_mode == MRec) model_store(l, r);
        end
        if (half == 0 && k == inj_bit) begin
          bus.i_start = st; bus.i_pause = pa; bus.i_stop = sp;
          model_pulse(st, pa, sp);
          if (was_rec && m_mode != MRec) aborted = 1'b1;
          @(negedge clk);
          bus.i_start = 1'b0; bus.i_pause = 1'b0; bus.i_stop = 1'b0;
          repeat (BclkHalf - 2) @(negedge clk);
        end else begin
          repeat (BclkHalf - 1) @(negedge clk);
        end
      end
    end
  endtask

  // Every strobe is matched against the model queue; latency measured from the LSB bclk rise.
  always @(negedge clk) begin
    if (!rst && bus.o_valid) begin
      exp_t e;
      valid_cnt++;
      last_data = bus.o_data;
      last_addr = bus.o_address;
      chk("valid_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("data", 32'(bus.o_data), 32'(e.data));
        chk("address", 32'(bus.o_address), 32'(e.addr));
      end
      chk("lsb_to_valid_cycles", 32'(($time - lsb_t) / 10), 32'd3);
    end
  end

  int base;

  initial begin
    bus.i_start = 1'b0; bus.i_pause = 1'b0; bus.i_stop = 1'b0;
    bus.i_aud_bclk = 1'b1; bus.i_aud_lrck = 1'b1; bus.i_aud_adcdat = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_valid", 32'(bus.o_valid), 32'd0);
    chk("reset_data", 32'(bus.o_data), 32'd0);
    chk("reset_address", 32'(bus.o_address), 32'd0);
    chk("reset_busy", 32'(bus.o_busy), 32'd0);
    chk("reset_full", 32'(bus.o_full), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single frame
    pulse(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("busy_after_start", 32'(bus.o_busy), 32'd1);
    send_frame(16'hA5C3, 16'h5A3C, -1, 1'b0, 1'b0, 1'b0);
    chk("t1_count", 32'(valid_cnt), 32'd1);
    chk("t1_address", 32'(last_addr), 32'd0);
`ifndef AUD_I2S_REC_STEREO_EN
    chk("t1_data_literal", 32'(last_data), 32'h0000A5C3);
`endif
    chk("t1_busy", 32'(bus.o_busy), 32'(m_mode == MRec));

    // Three consecutive frames
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    base = valid_cnt;
    send_frame(16'h0001, 16'h1111, -1, 1'b0, 1'b0, 1'b0);
    send_frame(16'h8000, 16'h2222, -1, 1'b0, 1'b0, 1'b0);
    send_frame(16'hFFFF, 16'h3333, -1, 1'b0, 1'b0, 1'b0);
    chk("t2_count", 32'(valid_cnt - base), 32'd3);
    chk("t2_last_address", 32'(last_addr), 32'd2);
`ifndef AUD_I2S_REC_STEREO_EN
    chk("t2_last_data_literal", 32'(last_data), 32'h0000FFFF);
`endif

    // Pause mid-word, resume
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    base = valid_cnt;
    send_frame(16'h1111, 16'h0F0F, -1, 1'b0, 1'b0, 1'b0);
    send_frame(16'hDEAD, 16'h0F0F, 8, 1'b0, 1'b1, 1'b0);
    chk("t3_busy_paused", 32'(bus.o_busy), 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    send_frame(16'h1234, 16'h0F0F, -1, 1'b0, 1'b0, 1'b0);
    chk("t3_count", 32'(valid_cnt - base), 32'd2);
    chk("t3_address", 32'(last_addr), 32'd1);
`ifndef AUD_I2S_REC_STEREO_EN
    chk("t3_data_literal", 32'(last_data), 32'h00001234);
`endif

    // Fill to MAX_ADDR
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    base = valid_cnt;
    for (int i = 0; i < 5; i++) send_frame(16'(i * 16'h1010 + 16'h0101), 16'h4444, -1, 1'b0, 1'b0, 1'b0);
    chk("t4_count", 32'(valid_cnt - base), 32'd4);
    chk("t4_last_address", 32'(last_addr), 32'd3);
    chk("t4_full", 32'(bus.o_full), 32'd1);
    chk("t4_busy", 32'(bus.o_busy), 32'd0);
    chk("t4_model_full", 32'(bus.o_full), 32'(m_full));

    // Simultaneous stop/pause/start mid-word
    pulse(1'b1, 1'b0, 1'b0);
    chk("t5_full_cleared", 32'(bus.o_full), 32'd0);
    base = valid_cnt;
    send_frame(16'h0BAD, 16'h5555, -1, 1'b0, 1'b0, 1'b0);
    send_frame(16'hCAFE, 16'h5555, 8, 1'b1, 1'b1, 1'b1);
    chk("t5_busy_after_stop", 32'(bus.o_busy), 32'd0);
    chk("t5_count", 32'(valid_cnt - base), 32'd1);
    pulse(1'b1, 1'b0, 1'b0);
    send_frame(16'h600D, 16'h5555, -1, 1'b0, 1'b0, 1'b0);
    chk("t5_restart_address", 32'(last_addr), 32'd0);
    chk("t5_count2", 32'(valid_cnt - base), 32'd2);

`ifdef AUD_I2S_REC_STEREO_EN
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    send_frame(16'h7FFF, 16'h0001, -1, 1'b0, 1'b0, 1'b0);
    chk("stereo_avg_pos", 32'(last_data), 32'h00004000);
    send_frame(16'h8000, 16'hFFFF, -1, 1'b0, 1'b0, 1'b0);
    chk("stereo_avg_neg", 32'(last_data), 32'h0000BFFF);
`endif

    // Reset while recording
    pulse(1'b1, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    m_mode = MIdle;
    m_ptr  = '0;
    m_full = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset_busy", 32'(bus.o_busy), 32'd0);
    chk("midreset_data", 32'(bus.o_data), 32'd0);
    chk("midreset_address", 32'(bus.o_address), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("expect_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
